// File: rtl/uo_uart_tx_pkg.sv
// Shared tt04 board definitions for the uo_out UART monitor: serial FSM
// encoding, default bit period and a counter-width helper.
package uo_uart_tx_pkg;

  // 2.08 MHz board clock divided down to 9600 baud, rounded.
  localparam int unsigned TT04_CLKS_PER_BIT = 217;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uo_uart_tx_8n1.sv
// 8N1 serialiser: takes one byte on a start strobe while idle and shifts it
// out LSB first between a low start bit and a high stop bit.
//
// state    | meaning
// ST_IDLE  | line high, waiting for start
// ST_START | start bit (low) for one bit period
// ST_DATA  | data bits 0..7, one bit period each
// ST_STOP  | stop bit (high) for one bit period
module uart_tx_8n1
  import uo_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = TT04_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_START;
          cnt_d   = CNT_LOAD;
          shift_d = data;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_LOAD;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line and busy are registered from the next state so tx never glitches.
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: rtl/uo_uart_tx.sv
// Streams changes of the uo_out bus over a UART: change detect, optional
// periodic re-send, a one-deep pending slot with newest-wins drop counting.
module uo_uart_tx
  import uo_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = TT04_CLKS_PER_BIT,
  parameter int unsigned RESEND_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] uo_in,
  output logic       tx,
  output logic       busy,
  output logic [7:0] dropped
);

  localparam int unsigned RS_W = cnt_width(RESEND_CYCLES);
  localparam bit RS_EN = (RESEND_CYCLES > 0);
  localparam logic [RS_W-1:0] RS_LAST = RS_W'((RESEND_CYCLES > 0) ? RESEND_CYCLES - 1 : 0);
  // The frame-start cycle itself counts as tick 0, so re-sends start exactly
  // RESEND_CYCLES apart.
  localparam logic [RS_W-1:0] RS_RELOAD = (RESEND_CYCLES > 1) ? RS_W'(1) : '0;

  logic [7:0]      last_q, last_d;
  logic            last_vld_q, last_vld_d;
  logic [7:0]      pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic [7:0]      drop_q, drop_d;
  logic [RS_W-1:0] rs_q, rs_d;

  logic       tx_busy;
  logic       take;
  logic       known;
  logic [7:0] newest;
  logic       rs_hit;
  logic       queue;

  assign take   = pend_vld_q & ~tx_busy;
  assign known  = pend_vld_q | last_vld_q;
  assign newest = pend_vld_q ? pend_q : last_q;
  assign rs_hit = RS_EN && (rs_q == RS_LAST) && !pend_vld_q;
  assign queue  = ena & (~known | (uo_in != newest) | rs_hit);

  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = drop_q;
    rs_d       = rs_q;

    if (take) begin
      last_d     = pend_q;
      last_vld_d = 1'b1;
      pend_vld_d = 1'b0;
      rs_d       = RS_RELOAD;
    end else if (rs_q != RS_LAST) begin
      rs_d = rs_q + RS_W'(1);
    end

    // A value handed to the serialiser this cycle is not a drop.
    if (queue) begin
      pend_d     = uo_in;
      pend_vld_d = 1'b1;
      if (pend_vld_q && !take && drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      drop_q     <= '0;
      rs_q       <= '0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      drop_q     <= drop_d;
      rs_q       <= rs_d;
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .start(take),
    .data (pend_q),
    .busy (tx_busy),
    .tx   (tx)
  );

  assign busy    = tx_busy;
  assign dropped = drop_q;

endmodule

// File: tb/tb_uo_uart_tx.sv
// Bench for uo_uart_tx: a line decoder rebuilds frames from tx and compares
// them with frames predicted by a cycle-timed model of the queueing rules.
module tb_uo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena0 = 1'b0, ena1 = 1'b0;
  logic [7:0] u0 = 8'h00, u1 = 8'h3C;
  logic       tx0, tx1, busy0, busy1;
  logic [7:0] drop0, drop1;

  uo_uart_tx #(.CLKS_PER_BIT(CPB), .RESEND_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena0), .uo_in(u0),
    .tx(tx0), .busy(busy0), .dropped(drop0)
  );

  uo_uart_tx #(.CLKS_PER_BIT(CPB), .RESEND_CYCLES(100)) dut_rs (
    .clk(clk), .rst_n(rst_n), .ena(ena1), .uo_in(u1),
    .tx(tx1), .busy(busy1), .dropped(drop1)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t exp0_q[$];
  frame_t exp1_q[$];

  // Reference model: pending/last bookkeeping plus the cycle the line frees up.
  int         rs_cfg[2] = '{0, 100};
  logic [7:0] m_pend[2], m_last[2];
  bit         m_pvld[2], m_lvld[2];
  int         m_drop[2], m_drop_now[2], m_fend[2], m_ltake[2];

  task automatic model_reset(input int i, input int c);
    m_pend[i] = 8'h00; m_last[i] = 8'h00;
    m_pvld[i] = 1'b0;  m_lvld[i] = 1'b0;
    m_drop[i] = 0;     m_drop_now[i] = 0;
    m_fend[i] = -1;    m_ltake[i] = c;
    if (i == 0) exp0_q.delete(); else exp1_q.delete();
  endtask

  task automatic model_step(input int i, input bit e, input logic [7:0] u, input int c);
    bit         pv, take, known, rs_hit, q;
    logic [7:0] newest;
    frame_t     f;
    m_drop_now[i] = m_drop[i];
    pv     = m_pvld[i];
    take   = pv && (c > m_fend[i]);
    known  = pv || m_lvld[i];
    newest = pv ? m_pend[i] : m_last[i];
    rs_hit = (rs_cfg[i] > 0) && !pv && ((c - m_ltake[i]) >= rs_cfg[i] - 1);
    q      = e && (!known || (u != newest) || rs_hit);
    if (take) begin
      f.data  = m_pend[i];
      f.start = c + 1;
      if (i == 0) exp0_q.push_back(f); else exp1_q.push_back(f);
      m_fend[i]  = c + FRAME;
      m_last[i]  = m_pend[i];
      m_lvld[i]  = 1'b1;
      m_ltake[i] = c;
      m_pvld[i]  = 1'b0;
    end
    if (q) begin
      if (pv && !take && m_drop[i] < 255) m_drop[i]++;
      m_pend[i] = u;
      m_pvld[i] = 1'b1;
    end
  endtask

  // Line decoder
  int         mpos[2], mstart[2], prev_start[2], frames_seen[2];
  bit         mbad[2], prev_vld[2];
  logic [7:0] mbyte[2];
  int         idle_busy_err = 0;

  task automatic frame_done(input int i);
    frame_t f;
    int     n;
    chk($sformatf("frame_shape%0d", i), int'(mbad[i]), 0);
    frames_seen[i]++;
    n = (i == 0) ? exp0_q.size() : exp1_q.size();
    chk($sformatf("frame_expected%0d", i), int'(n > 0), 1);
    if (n > 0) begin
      f = (i == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
      chk($sformatf("frame_data%0d", i), int'(mbyte[i]), int'(f.data));
      chk($sformatf("frame_start%0d", i), mstart[i], f.start);
    end
    if (i == 1 && prev_vld[1]) chk("resend_gap", mstart[1] - prev_start[1], 100);
    prev_start[i] = mstart[i];
    prev_vld[i]   = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mpos[i] = 0; mstart[i] = 0; prev_start[i] = 0; frames_seen[i] = 0;
      mbad[i] = 1'b0; prev_vld[i] = 1'b0; mbyte[i] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic t, b;
        int   j, k;
        t = (i == 0) ? tx0 : tx1;
        b = (i == 0) ? busy0 : busy1;
        if (!rst_n) begin
          mpos[i] = 0;
          prev_vld[i] = 1'b0;
        end else if (mpos[i] == 0) begin
          if (t == 1'b0) begin
            mstart[i] = cyc;
            mpos[i]   = 1;
            mbad[i]   = !b;
            mbyte[i]  = 8'h00;
          end else if (b) begin
            idle_busy_err++;
          end
        end else begin
          j = mpos[i];
          if (!b) mbad[i] = 1'b1;
          if (j < CPB) begin
            if (t != 1'b0) mbad[i] = 1'b1;
          end else if (j < 9 * CPB) begin
            k = (j - CPB) / CPB;
            if ((j - CPB) % CPB == 0) mbyte[i][k] = t;
            else if (t != mbyte[i][k]) mbad[i] = 1'b1;
          end else if (t != 1'b1) begin
            mbad[i] = 1'b1;
          end
          if (j == FRAME - 1) begin
            frame_done(i);
            mpos[i] = 0;
          end else begin
            mpos[i] = j + 1;
          end
        end
      end
    end
  end

  task automatic step(input bit e, input logic [7:0] u);
    @(posedge clk);
    #1;
    ena0 = e;
    u0   = u;
    model_step(0, e, u, cyc);
    model_step(1, ena1, u1, cyc);
  endtask

  task automatic check_drop(input string tag);
    chk({tag, "_drop0"}, int'(drop0), m_drop_now[0]);
    chk({tag, "_drop1"}, int'(drop1), m_drop_now[1]);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_tx0", int'(tx0), 1);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_tx1", int'(tx1), 1);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_drop0", int'(drop0), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset(0, cyc);
    model_reset(1, cyc);
    model_step(0, ena0, u0, cyc);
    model_step(1, ena1, u1, cyc);
  endtask

  initial begin
    int         base;
    bit         e;
    logic [7:0] u;

    repeat (3) @(posedge clk);
    #1;
    chk("init_tx0", int'(tx0), 1);
    chk("init_busy0", int'(busy0), 0);
    chk("init_drop0", int'(drop0), 0);
    chk("init_tx1", int'(tx1), 1);
    chk("init_busy1", int'(busy1), 0);
    chk("init_drop1", int'(drop1), 0);

    // First frame right after reset release
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ena0 = 1'b1; u0 = 8'hA5; ena1 = 1'b1;
    model_reset(0, cyc);
    model_reset(1, cyc);
    model_step(0, ena0, u0, cyc);
    model_step(1, ena1, u1, cyc);
    repeat (50) step(1'b1, 8'hA5);
    chk("a5_frames", frames_seen[0], 1);

    // Steady value, no re-send
    base = frames_seen[0];
    repeat (200) step(1'b1, 8'hA5);
    chk("steady_no_frames", frames_seen[0] - base, 0);
    chk("steady_drop", int'(drop0), 0);

    // Burst of changes during a frame
    repeat (6) step(1'b1, 8'h5A);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    repeat (100) step(1'b1, 8'h03);
    chk("burst_drop", int'(drop0), 2);
    check_drop("burst");

    // Capture disabled while the bus toggles
    base = frames_seen[0];
    for (int k = 0; k < 60; k++) step(1'b0, 8'(8'h40 + k));
    chk("ena0_no_frames", frames_seen[0] - base, 0);
    chk("ena0_busy", int'(busy0), 0);
    chk("ena0_tx", int'(tx0), 1);
    repeat (50) step(1'b1, 8'h7B);
    chk("ena1_one_frame", frames_seen[0] - base, 1);

    // Reset in the middle of the data bits
    repeat (15) step(1'b1, 8'hC3);
    pulse_reset();
    repeat (60) step(1'b1, 8'hC3);
    check_drop("post_rst");

    // Random stimulus
    e = 1'b1;
    u = 8'h00;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 29) == 0) e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) u = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) u = 8'($urandom);
      step(e, u);
    end
    check_drop("random");

    // Continuous churn drives the drop counter into saturation
    for (int k = 0; k < 400; k++) step(1'b1, 8'(k));
    chk("drop_sat", int'(drop0), 255);
    check_drop("sat");

    repeat (100) step(1'b1, 8'hEE);
    check_drop("drain");
    chk("exp0_empty", exp0_q.size(), 0);
    chk("exp1_left", int'(exp1_q.size() <= 1), 1);
    chk("idle_busy_err", idle_busy_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uo_uart_tx.md
UO_UART_TX -- requirements
Module: uo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clocks per UART bit (2.08 MHz / 9600 baud, rounded).
REQ-002 SHALL have parameter RESEND_CYCLES, default 0, clocks between forced re-sends of an unchanged value; 0 disables re-send.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ena  input  1  capture enable; high permits new values to be queued.
REQ-006 SHALL have port uo_in  input  8  design output bus, synchronous to clk.
REQ-007 SHALL have port tx  output  1  UART 8N1 serial line, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is on the line.
REQ-009 SHALL have port dropped  output  8  saturating count of pending values overwritten before send.

Function
REQ-010 SHALL hold a last_sent register (8 bits plus valid flag) and a one-deep pending register (8 bits plus valid flag).
REQ-011 SHALL queue uo_in into pending in any cycle where ena=1 and uo_in differs from the newest known value (pending data if pending valid, else last_sent), or last_sent is invalid.
REQ-012 SHALL queue uo_in when ena=1, RESEND_CYCLES>0, the re-send timer reaches RESEND_CYCLES-1 and nothing is pending; the timer SHALL restart on every frame start.
REQ-013 SHALL, when a queue event finds pending already valid, overwrite pending (newest wins) and increment dropped, saturating at 255.
REQ-014 SHALL run FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: tx=1, busy=0; if pending valid, the next cycle enters START, moves pending into the shift register, clears pending valid, and copies the data to last_sent with valid=1.
REQ-016 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: tx = shift bit, LSB first, each bit CLKS_PER_BIT cycles; after bit 7, STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE; busy=1 in START, DATA and STOP.
REQ-019 SHALL produce a frame of exactly 10*CLKS_PER_BIT cycles, with the first start-bit cycle one clock after the queue event when idle.
REQ-020 SHALL allow a queue event in the same cycle the FSM empties pending; the FSM takes the old pending value, the new value becomes pending, and dropped does not increment.
REQ-021 SHALL allow pending to fill during a frame; it is sent starting in the cycle after STOP completes (IDLE lasts one cycle).
REQ-022 SHALL, when ena falls, stop new queue events; an in-flight frame and any already-pending value SHALL still be sent.
REQ-023 SHALL use a baud counter of width clog2(CLKS_PER_BIT) counting down to 0, and a 3-bit bit index; both SHALL wrap only under FSM control.

Reset
REQ-024 SHALL, on rst_n=0 and asynchronously, force: FSM IDLE, tx=1, busy=0, dropped=0, pending valid=0, last_sent valid=0, counters 0.
REQ-025 SHALL abort an in-flight frame on reset with tx returning high immediately; no partial frame resumes after reset.
REQ-026 SHALL treat the first cycle with ena=1 after reset as a queue event, because last_sent is invalid.

Structure
REQ-027 SHALL place the FSM state encoding and the default CLKS_PER_BIT in the shared tt04 board package.
REQ-028 SHALL split into one sub-module, uart_tx_8n1 (byte in, start strobe, busy, tx), with change-detect, pending and drop logic in the top module.

Verification (bench uses CLKS_PER_BIT=4)
REQ-029 Reset release, ena=1, uo_in=0xA5 -> start bit 1 clk later; tx bits 1,0,1,0,0,1,0,1 each 4 clk; stop high; 40 clk total; busy high throughout.
REQ-030 uo_in steady 0xA5 after the send, RESEND_CYCLES=0 -> no further frames for 200 clk; dropped=0.
REQ-031 During a frame, uo_in 0x01 -> 0x02 -> 0x03 on consecutive clocks -> dropped=2; the next frame carries 0x03 and starts 1 clk after stop ends.
REQ-032 ena=0 with uo_in toggling -> tx stays high and busy=0; ena=1 -> the current value is sent once.
REQ-033 rst_n low for 1 clk mid-DATA -> tx=1, busy=0 at once; after release with ena=1, the current uo_in is sent as a full frame.
REQ-034 RESEND_CYCLES=100, uo_in constant 0x3C -> identical 0x3C frames start every 100 clk.
